// File: rtl/pacman_pkg.sv
// Shared types for the Pac-Man heading controller: direction codes, FSM states
// and the reversal helper.
package pacman_pkg;

  typedef logic [1:0] dir_t;

  localparam dir_t DIR_UP    = 2'd0;
  localparam dir_t DIR_DOWN  = 2'd1;
  localparam dir_t DIR_LEFT  = 2'd2;
  localparam dir_t DIR_RIGHT = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_BLOCKED = 2'd2
  } state_t;

  // UP<->DOWN and LEFT<->RIGHT differ only in bit 0 of the code.
  function automatic dir_t opposite(input dir_t d);
    return d ^ 2'b01;
  endfunction

endpackage

// File: rtl/pacman_dir_ctrl_if.sv
// Button/maze/heading bundle between the game logic (master) and the
// heading controller (slave).
interface pacman_dir_ctrl_if;
  import pacman_pkg::*;

  logic       b3;
  logic       b2;
  logic       b1;
  logic       b0;
  logic       move_tick;
  logic [3:0] turn_ok;
  dir_t       cur_dir;
  logic       moving;
  logic       req_valid;
  dir_t       req_dir;
  logic [3:0] press;

  modport master (
    output b3, b2, b1, b0, move_tick, turn_ok,
    input  cur_dir, moving, req_valid, req_dir, press
  );

  modport slave (
    input  b3, b2, b1, b0, move_tick, turn_ok,
    output cur_dir, moving, req_valid, req_dir, press
  );

endinterface

// File: rtl/btn_edge_prio.sv
// Rising-edge detection on the four debounced buttons plus a fixed-priority
// pick of one winning direction (UP > DOWN > LEFT > RIGHT).
module btn_edge_prio
  import pacman_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] b,            // {UP, DOWN, LEFT, RIGHT}
  output logic [3:0] rise,
  output logic       winner_valid,
  output dir_t       winner_dir
);

  logic [3:0] b_prev;

  // NOTE: asynchronous active-low reset; clearing b_prev makes a button held
  // through reset release register as a fresh press.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      b_prev <= '0;
    end else begin
      // NOTE: non-blocking assignment for every sequential register.
      b_prev <= b;
    end
  end

  assign rise = b & ~b_prev;

  // Button bit index and direction code run in opposite orders.
  always_comb begin
    // NOTE: defaults first so no path leaves an output unassigned (no latch).
    winner_valid = 1'b1;
    winner_dir   = DIR_UP;
    if (rise[3])      winner_dir = DIR_UP;
    else if (rise[2]) winner_dir = DIR_DOWN;
    else if (rise[1]) winner_dir = DIR_LEFT;
    else if (rise[0]) winner_dir = DIR_RIGHT;
    else              winner_valid = 1'b0;
  end

endmodule

// File: rtl/pacman_dir_ctrl.sv
// Pac-Man heading controller: buffers one turn request and applies it at a
// legal tile centre. Optional PACMAN_INSTANT_REVERSE_EN allows immediate reversal.
module pacman_dir_ctrl
  import pacman_pkg::*;
#(
  parameter int HOLD_TICKS = 8,
  parameter int CNT_W      = 4
) (
  input  logic              d_clk,
  input  logic              rst_n,
  pacman_dir_ctrl_if.slave  bus
);

  logic [3:0] rise;
  logic       winner_valid;
  dir_t       winner_dir;

  btn_edge_prio u_edge (
    .clk          (d_clk),
    .rst_n        (rst_n),
    .b            ({bus.b3, bus.b2, bus.b1, bus.b0}),
    .rise         (rise),
    .winner_valid (winner_valid),
    .winner_dir   (winner_dir)
  );

  state_t             state;
  dir_t               cur_dir;
  dir_t               req_dir;
  logic               moving;
  logic               req_valid;
  logic [3:0]         press;
  logic [CNT_W-1:0]   hold_cnt;

  // A same-cycle press bypasses the buffer when choosing the candidate turn.
  logic cand_valid;
  dir_t cand_dir;
  logic cand_legal;
  logic cur_open;
  logic rev_now;

  assign cand_valid = winner_valid | req_valid;
  assign cand_dir   = winner_valid ? winner_dir : req_dir;
  assign cand_legal = cand_valid & bus.turn_ok[cand_dir];
  assign cur_open   = bus.turn_ok[cur_dir];

`ifdef PACMAN_INSTANT_REVERSE_EN
  // The tile just left is always open, so turn_ok is not needed here.
  assign rev_now = winner_valid && (state != ST_IDLE) &&
                   (winner_dir == opposite(cur_dir));
`else
  assign rev_now = 1'b0;
`endif

  always_ff @(posedge d_clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      cur_dir   <= DIR_LEFT;
      moving    <= 1'b0;
      req_valid <= 1'b0;
      req_dir   <= DIR_LEFT;
      press     <= '0;
      hold_cnt  <= '0;
    end else begin
      press <= rise;

      if (rev_now) begin
        cur_dir   <= winner_dir;
        state     <= ST_RUN;
        moving    <= 1'b1;
        req_valid <= 1'b0;
        hold_cnt  <= '0;
      end else if (bus.move_tick) begin
        if (cand_legal) begin
          cur_dir   <= cand_dir;
          req_valid <= 1'b0;
          hold_cnt  <= '0;
          state     <= ST_RUN;
          moving    <= 1'b1;
        end else begin
          // IDLE only leaves through a legal request.
          if (state != ST_IDLE) begin
            if (cur_open) begin
              state  <= ST_RUN;
              moving <= 1'b1;
            end else begin
              state  <= ST_BLOCKED;
              moving <= 1'b0;
            end
          end

          // A fresh press outranks expiry of the old request.
          if (winner_valid) begin
            req_dir   <= winner_dir;
            req_valid <= 1'b1;
            hold_cnt  <= CNT_W'(HOLD_TICKS);
          end else if (req_valid) begin
            if (hold_cnt <= CNT_W'(1)) begin
              req_valid <= 1'b0;
              hold_cnt  <= '0;
            end else begin
              hold_cnt <= hold_cnt - 1'b1;
            end
          end
        end
      end else if (winner_valid) begin
        req_dir   <= winner_dir;
        req_valid <= 1'b1;
        hold_cnt  <= CNT_W'(HOLD_TICKS);
      end
    end
  end

  assign bus.cur_dir   = cur_dir;
  assign bus.moving    = moving;
  assign bus.req_valid = req_valid;
  assign bus.req_dir   = req_dir;
  assign bus.press     = press;

endmodule

// File: tb/tb_pacman_dir_ctrl.sv
// Directed, table-driven bench for pacman_dir_ctrl (HOLD_TICKS = 8).
`timescale 1ns/1ps
module tb_pacman_dir_ctrl;

  logic d_clk = 1'b0;
  logic rst_n = 1'b0;

  pacman_dir_ctrl_if bus ();

  pacman_dir_ctrl #(.HOLD_TICKS(8), .CNT_W(4)) dut (
    .d_clk (d_clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 d_clk = ~d_clk;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [3:0] b;
    logic       tick;
    logic [3:0] ok;
    logic [1:0] cur;
    logic       mov;
    logic       rv;
    logic [1:0] rd;
    logic [3:0] pr;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [3:0] b, input logic tick, input logic [3:0] ok);
    {bus.b3, bus.b2, bus.b1, bus.b0} = b;
    bus.move_tick = tick;
    bus.turn_ok   = ok;
  endtask

  task automatic cycle();
    @(posedge d_clk);
    #1;
  endtask

  task automatic add(input logic [3:0] b, input logic tick, input logic [3:0] ok,
                     input logic [1:0] cur, input logic mov, input logic rv,
                     input logic [1:0] rd, input logic [3:0] pr);
    vec_t v;
    v.b = b; v.tick = tick; v.ok = ok; v.cur = cur;
    v.mov = mov; v.rv = rv; v.rd = rd; v.pr = pr;
    vecs.push_back(v);
  endtask

  task automatic check_outs(input string tag, input logic [1:0] cur, input logic mov,
                            input logic rv, input logic [1:0] rd, input logic [3:0] pr);
    check({tag, ".cur_dir"},   32'(bus.cur_dir),   32'(cur));
    check({tag, ".moving"},    32'(bus.moving),    32'(mov));
    check({tag, ".req_valid"}, 32'(bus.req_valid), 32'(rv));
    check({tag, ".req_dir"},   32'(bus.req_dir),   32'(rd));
    check({tag, ".press"},     32'(bus.press),     32'(pr));
  endtask

  initial begin
    // Columns: b{U,D,L,R}, tick, turn_ok, cur_dir, moving, req_valid, req_dir, press
    add(4'b1000, 1'b0, 4'b0000, 2'd2, 1'b0, 1'b1, 2'd0, 4'b1000); // UP press from IDLE
    add(4'b1000, 1'b0, 4'b0000, 2'd2, 1'b0, 1'b1, 2'd0, 4'b0000);
    add(4'b1000, 1'b0, 4'b0000, 2'd2, 1'b0, 1'b1, 2'd0, 4'b0000);
    add(4'b1000, 1'b1, 4'b0001, 2'd0, 1'b1, 1'b0, 2'd0, 4'b0000); // tick, UP legal
    add(4'b0000, 1'b0, 4'b0000, 2'd0, 1'b1, 1'b0, 2'd0, 4'b0000);
    add(4'b0010, 1'b0, 4'b0000, 2'd0, 1'b1, 1'b1, 2'd2, 4'b0010); // LEFT request
    add(4'b0000, 1'b1, 4'b0100, 2'd2, 1'b1, 1'b0, 2'd2, 4'b0000); // turn LEFT
    add(4'b0101, 1'b0, 4'b0000, 2'd2, 1'b1, 1'b1, 2'd1, 4'b0101); // DOWN+RIGHT together
    add(4'b0000, 1'b0, 4'b0000, 2'd2, 1'b1, 1'b1, 2'd1, 4'b0000);
    for (int i = 0; i < 7; i++)                                   // DOWN illegal, ticks 1..7
      add(4'b0000, 1'b1, 4'b0100, 2'd2, 1'b1, 1'b1, 2'd1, 4'b0000);
    add(4'b0000, 1'b1, 4'b0100, 2'd2, 1'b1, 1'b0, 2'd1, 4'b0000); // 8th tick expires
    add(4'b0000, 1'b1, 4'b0010, 2'd2, 1'b0, 1'b0, 2'd1, 4'b0000); // no turn, blocked
    add(4'b0000, 1'b1, 4'b0100, 2'd2, 1'b1, 1'b0, 2'd1, 4'b0000); // resume
    add(4'b0000, 1'b1, 4'b0000, 2'd2, 1'b0, 1'b0, 2'd1, 4'b0000); // blocked again
    add(4'b0000, 1'b0, 4'b0100, 2'd2, 1'b0, 1'b0, 2'd1, 4'b0000); // open but no tick
    add(4'b0000, 1'b1, 4'b0100, 2'd2, 1'b1, 1'b0, 2'd1, 4'b0000); // resume on tick
`ifdef PACMAN_INSTANT_REVERSE_EN
    add(4'b0001, 1'b0, 4'b0000, 2'd3, 1'b1, 1'b0, 2'd1, 4'b0001); // reverse at once
    add(4'b0001, 1'b0, 4'b0000, 2'd3, 1'b1, 1'b0, 2'd1, 4'b0000);
    add(4'b0000, 1'b1, 4'b1000, 2'd3, 1'b1, 1'b0, 2'd1, 4'b0000);
`else
    add(4'b0001, 1'b0, 4'b0000, 2'd2, 1'b1, 1'b1, 2'd3, 4'b0001); // reverse is buffered
    add(4'b0001, 1'b0, 4'b0000, 2'd2, 1'b1, 1'b1, 2'd3, 4'b0000);
    add(4'b0000, 1'b1, 4'b1000, 2'd3, 1'b1, 1'b0, 2'd3, 4'b0000);
`endif

    drive(4'b0000, 1'b0, 4'b0000);
    rst_n = 1'b0;
    repeat (2) @(posedge d_clk);
    #1 rst_n = 1'b1;
    repeat (5) cycle();
    check_outs("reset", 2'd2, 1'b0, 1'b0, 2'd2, 4'b0000);

    foreach (vecs[i]) begin
      drive(vecs[i].b, vecs[i].tick, vecs[i].ok);
      cycle();
      check_outs($sformatf("vec%0d", i), vecs[i].cur, vecs[i].mov, vecs[i].rv,
                 vecs[i].rd, vecs[i].pr);
    end

    // Press on the tick that would expire the request reloads the counter.
    drive(4'b0100, 1'b0, 4'b0000);
    cycle();
    check("reload.first_req", 32'(bus.req_dir), 32'd1);
    drive(4'b0000, 1'b1, 4'b1000);
    repeat (7) cycle();
    check("reload.before_expiry", 32'(bus.req_valid), 32'd1);
    drive(4'b1000, 1'b1, 4'b1000);
    cycle();
    check("reload.press_wins_valid", 32'(bus.req_valid), 32'd1);
    check("reload.press_wins_dir",   32'(bus.req_dir),   32'd0);
    check("reload.heading",          32'(bus.cur_dir),   32'd3);
    repeat (7) cycle();
    check("reload.seven_more", 32'(bus.req_valid), 32'd1);
    cycle();
    check("reload.expired", 32'(bus.req_valid), 32'd0);
    check("reload.moving",  32'(bus.moving),    32'd1);

    // Asynchronous reset mid-RUN, with UP held through release.
    drive(4'b1000, 1'b0, 4'b1000);
    #2 rst_n = 1'b0;
    #1;
    check_outs("async_rst", 2'd2, 1'b0, 1'b0, 2'd2, 4'b0000);
    #2 rst_n = 1'b1;
    cycle();
    check_outs("held_btn", 2'd2, 1'b0, 1'b1, 2'd0, 4'b1000);
    drive(4'b1000, 1'b1, 4'b0100);
    cycle();
    check_outs("idle_stays", 2'd2, 1'b0, 1'b1, 2'd0, 4'b0000);
    drive(4'b1000, 1'b1, 4'b0001);
    cycle();
    check_outs("idle_leaves", 2'd0, 1'b1, 1'b0, 2'd0, 4'b0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
